riscv_lsu: RTL
==============

# riscv_lsu

Load/store unit sitting directly downstream of the ALU and instruction decoder in the processor data path. It takes the ALU-computed address, the store data from register file read port 2, and the decoder's memory request, write-enable and size signals. It runs a request/grant/valid handshake with the data memory and returns aligned, sign- or zero-extended load data for register write-back. While an access is outstanding, it stalls the program counter.

## Interface
- `clk_i`  input  1  — system clock; all state changes on the rising edge.
- `reset_i`  input  1  — asynchronous, active-low reset.
- `lsu_addr_i`  input  32  — byte address from the ALU result.
- `lsu_data_i`  input  32  — store data from RF read port 2.
- `lsu_req_i`  input  1  — memory access request from the decoder (`mem_req_o`).
- `lsu_we_i`  input  1  — 1 = store, 0 = load (decoder `mem_we_o`).
- `lsu_size_i`  input  3  — funct3 encoding:
  - 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
  - Any other code is treated as W.
- `lsu_data_o`  output  32  — extended load result.
- `lsu_stall_req_o`  output  1  — holds the PC while an access is incomplete.
- `lsu_misalign_o`  output  1  — misaligned-access flag (see Configuration).
- `data_req_o`  output  1  — memory request.
- `data_we_o`  output  1  — memory write enable.
- `data_be_o`  output  4  — byte enables.
- `data_addr_o`  output  32  — word-aligned address: `{addr[31:2], 2'b00}`.
- `data_wdata_o`  output  32  — replicated store data.
- `data_gnt_i`  input  1  — memory accepted the request.
- `data_rvalid_i`  input  1  — response valid; carries load data, and acknowledges stores.
- `data_rdata_i`  input  32  — load data word.

## Operation
- **FSM states:** IDLE, REQ, RESP, DONE.
- **IDLE**
  - On `lsu_req_i=1`, latch `lsu_addr_i`, `lsu_data_i`, `lsu_we_i` and `lsu_size_i` into internal registers, then go to REQ.
  - When the misaligned check is compiled in and the access is misaligned, go to DONE instead.
- **REQ:** `data_req_o=1`. Address, write enable, byte enables and write data are driven from the latched values. Stay in REQ until `data_gnt_i=1`, then go to RESP.
- **RESP:** wait for `data_rvalid_i=1`.
  - On a load, capture the extended data into the `lsu_data_o` register.
  - Go to DONE.
- **DONE:** one cycle, then unconditionally return to IDLE.
- **Stall:** `lsu_stall_req_o = lsu_req_i & (state != DONE)`, combinational. The core holds its request stable while stalled.
- **Byte enables** (offset = latched `addr[1:0]`):
  - B/BU: `4'b0001 << addr[1:0]`.
  - H/HU: `addr[1] ? 4'b1100 : 4'b0011`.
  - W: `4'b1111`.
- **Write data replication:**
  - B: `{4{d[7:0]}}`.
  - H: `{2{d[15:0]}}`.
  - W: `d`.
- **Load extraction:**
  - B/BU: the byte at the offset, sign- or zero-extended to 32 bits.
  - H/HU: the half selected by `addr[1]`, sign- or zero-extended.
  - W: the whole word.
- **Stores:** `lsu_data_o` keeps its previous value.

## Timing
- **Reset:** state is IDLE. Every output is 0, including `lsu_data_o`, latched fields and `lsu_misalign_o`.
- **Reset mid-operation:** any outstanding request is abandoned and `data_req_o` drops immediately (asynchronously).
- **Minimum latency** with zero-wait grant and `rvalid` one cycle after grant:
  - Request seen at cycle 0 (IDLE).
  - `data_req_o=1` at cycle 1.
  - RESP at cycle 2, where `rvalid` arrives.
  - DONE at cycle 3: stall low and `lsu_data_o` valid.
  - Total: stall high for 3 cycles.
- **Grant:** each extra cycle of `data_gnt_i=0` adds one REQ cycle. `data_req_o` and all `data_*` outputs stay constant until the grant.
- **Response:** `data_rvalid_i` during IDLE, REQ or DONE is ignored. `rvalid` must arrive at least one cycle after `gnt`.
- **Back-to-back accesses:** a new `lsu_req_i` in the cycle after DONE is accepted normally. There is no bubble beyond the IDLE accept cycle.
- **`lsu_req_i` dropped mid-access:** the FSM still completes the transaction; the stall output follows the request.

## Configuration
- Macro `LSU_MISALIGN_EXC_EN`.
- **Defined:**
  - A misaligned access is H/HU with `addr[0]=1`, or W with `addr[1:0]!=0`.
  - On a misaligned access, IDLE goes straight to DONE and no memory request is issued.
  - `lsu_misalign_o=1` for the DONE cycle only.
  - `lsu_data_o` is unchanged.
- **Undefined:**
  - `lsu_misalign_o` is tied to 0.
  - Offending low address bits are ignored: W uses offset 0 and H uses `addr[1]` only. The access proceeds normally.

## Test plan
- **LW:** `addr=0x100`, `rdata=0xDEADBEEF`, `gnt` and `rvalid` zero-wait → `data_be_o=1111`, `addr_o=0x100`; `lsu_data_o=0xDEADBEEF` in DONE; stall high exactly 3 cycles.
- **LB vs LBU:** `addr=0x103`, `rdata=0x80FF1234` → LB gives `0xFFFFFF80`, LBU gives `0x00000080`; `be=1000`.
- **SH:** `addr=0x202`, `data=0x0000ABCD` → `wdata=0xABCDABCD`, `be=1100`, `we=1`; `lsu_data_o` unchanged.
- **Grant stall:** `data_gnt_i` held 0 for 5 cycles → `data_req_o` and all `data_*` outputs constant for 6 REQ cycles, and stall stays high until DONE.
- **Reset mid-operation:** `reset_i` asserted low while in RESP → `data_req_o=0`, stall=0 and `lsu_data_o=0` immediately; a later `rvalid` is ignored.
- **Misaligned access:** LW at `0x101`:
  - With `LSU_MISALIGN_EXC_EN`: no `data_req_o`; `lsu_misalign_o` pulses 1 cycle at cycle 1.
  - Without it: access to `0x100` with `be=1111`.

Source files
------------

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit with a req/gnt/rvalid data-memory handshake and PC stall.
// Optional macro LSU_MISALIGN_EXC_EN: flag misaligned H/W accesses instead of forcing alignment.
module riscv_lsu (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_misalign_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  output logic [1:0]  debug_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Handshake: data_req_o is held with stable data_* until data_gnt_i; the response
  // is data_rvalid_i, accepted only in RESP (at least one cycle after the grant).

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [2:0]  size_q;
  logic [31:0] rdata_q;
  logic        misalign_in;

  logic        is_byte;
  logic        is_half;
  logic        is_signed;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext;
  logic        in_req;

  // funct3 low bits 00 = byte, 01 = half; every other code behaves as a word.
  assign is_byte   = (size_q[1:0] == 2'b00);
  assign is_half   = (size_q[1:0] == 2'b01);
  assign is_signed = ~size_q[2];

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata_q;
    if (is_byte) begin
      be        = 4'b0001 << addr_q[1:0];
      wdata_rep = {4{wdata_q[7:0]}};
    end else if (is_half) begin
      be        = addr_q[1] ? 4'b1100 : 4'b0011;
      wdata_rep = {2{wdata_q[15:0]}};
    end
  end

  always_comb begin
    ld_byte = data_rdata_i[7:0];
    case (addr_q[1:0])
      2'd1:    ld_byte = data_rdata_i[15:8];
      2'd2:    ld_byte = data_rdata_i[23:16];
      2'd3:    ld_byte = data_rdata_i[31:24];
      default: ld_byte = data_rdata_i[7:0];
    endcase
    ld_half  = addr_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    load_ext = data_rdata_i;
    if (is_byte)
      load_ext = {{24{is_signed & ld_byte[7]}}, ld_byte};
    else if (is_half)
      load_ext = {{16{is_signed & ld_half[15]}}, ld_half};
  end

`ifdef LSU_MISALIGN_EXC_EN
  logic misalign_q;
  assign misalign_in = ((lsu_size_i[1:0] == 2'b01) & lsu_addr_i[0]) |
                       ((lsu_size_i[1] == 1'b1) & (lsu_addr_i[1:0] != 2'b00));
  assign lsu_misalign_o = (state == DONE) & misalign_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)
      misalign_q <= 1'b0;
    else if (state == IDLE && lsu_req_i)
      misalign_q <= misalign_in;
  end
`else
  assign misalign_in    = 1'b0;
  assign lsu_misalign_o = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (lsu_req_i) state_nxt = misalign_in ? DONE : REQ;
      REQ:     if (data_gnt_i) state_nxt = RESP;
      RESP:    if (data_rvalid_i) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && lsu_req_i) begin
        addr_q  <= lsu_addr_i;
        wdata_q <= lsu_data_i;
        we_q    <= lsu_we_i;
        size_q  <= lsu_size_i;
      end
      if (state == RESP && data_rvalid_i && !we_q)
        rdata_q <= load_ext;
    end
  end

  // Memory-side outputs are zero outside REQ so reset leaves every output at 0.
  assign in_req          = (state == REQ);
  assign data_req_o      = in_req;
  assign data_we_o       = in_req & we_q;
  assign data_be_o       = in_req ? be : 4'b0000;
  assign data_addr_o     = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign data_wdata_o    = in_req ? wdata_rep : 32'h0;
  assign lsu_data_o      = rdata_q;
  assign lsu_stall_req_o = reset_i & lsu_req_i & (state != DONE);
  assign debug_state     = state;

endmodule
